pipe3_alu_core: RTL and testbench
=================================

// Module: pipe3_alu_core
// PURPOSE
//  Parametrised 3-stage (fetch/execute/writeback) integer pipeline with internal register
//  file, 8-op ALU, EX-stage operand forwarding, global stall, HALT and retire counter.
//  Sits between an external combinational-read instruction memory and debug/test logic.
// PARAMETERS
//  DATA_W     32  datapath and register width
//  NREGS      32  register count, power of 2, 2..32 (index = low log2(NREGS) bits of field)
//  IMEM_DEPTH 32  instruction words; word index = pc[..:2] mod IMEM_DEPTH
//  R0_ZERO    1   1: reg 0 reads 0 and ignores writes
// PORTS
//  clk        in  1       clock
//  rst        in  1       synchronous active-high reset
//  en         in  1       1: pipeline advances; 0: full stall, all state held
//  imem_addr  out 32      byte PC of the fetch stage (word-aligned)
//  imem_rdata in  32      instruction at imem_addr, same cycle (combinational memory)
//  wb_valid   out 1       registered: writeback stage holds a register write
//  wb_addr    out 5       destination register of that write
//  wb_data    out DATA_W  write data
//  dbg_raddr  in  5       debug register index
//  dbg_rdata  out DATA_W  combinational read of the register file (post-write state)
//  halted     out 1       sticky, set when HALT executes
//  retired    out 32      count of retired register-writing instructions, wraps
// BEHAVIOUR
//  Instr: [31:29] op, [28:24] rd, [23:19] rs1, [18:14] rs2, [13:0] imm.
//  Ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LDI (rd=zero-ext imm),
//   110 NOP, 111 HALT. Arithmetic is mod 2^DATA_W; carry/borrow discarded.
//  Reset: pc=0, F/EX and EX/WB valid=0, wb_valid=0, wb_addr=0, wb_data=0, halted=0,
//   retired=0, every register=0.
//  Fetch (edge k, en=1, !halted, no HALT in EX): IF/EX <= imem_rdata, valid=1; pc += 4.
//  Execute (edge k+1): ALU result latched into EX/WB with rd; ops 000-101 set wb_valid.
//  Writeback (edge k+2): regfile[rd] <= wb_data; retired += 1.
//   Not counted: NOP, HALT, and rd=0 writes when R0_ZERO=1.
//  Latency: written value visible on dbg_rdata in the cycle after edge k+2.
//  Forwarding: if EX rs1/rs2 == EX/WB rd with wb_valid (and not reg 0 when R0_ZERO),
//   EX uses wb_data. This covers back-to-back dependencies with no bubbles.
//   Two-ahead producer is already in regfile.
//  HALT: at the edge HALT leaves EX, halted <= 1, and the instruction fetched behind it
//   is squashed (valid=0). Older instructions finish writeback. pc freezes at HALT pc+8.
//   Only rst clears halted.
//  en=0: pc, pipe registers, regfile and retired all hold. wb_* outputs hold, but no
//   regfile write or retire occurs. Resuming repeats nothing and skips nothing.
//  PC wrap: index wraps mod IMEM_DEPTH. pc itself wraps at 2^32.
//  rst mid-operation: all in-flight instructions are discarded; no write occurs on the
//   reset edge.
//  R0_ZERO=0: reg 0 is an ordinary register.
// TESTING
//  LDI r1,5; LDI r2,3; ADD r3,r1,r2; SUB r4,r2,r1 -> r3=8, r4=0xFFFFFFFE, retired=4.
//  Back-to-back dependency: LDI r1,7; ADD r1,r1,r1; ADD r1,r1,r1
//   -> r1=28 with no stall (forwarding).
//  en low 3 cycles mid-stream -> same final regs/retired as unstalled run; no double write.
//  HALT then LDI r5,9 -> halted=1, r5 stays 0, pc holds, retired excludes HALT.
//  LDI r0,1 (R0_ZERO=1) -> dbg r0=0, retired unchanged.
//  IMEM_DEPTH=4: 5th fetch reads word 0.
//  rst asserted while ADD in EX -> no write, all regs 0.

Source files
------------

// File: rtl/pipe3_alu_core.sv
// pipe3_alu_core: three-stage (fetch / execute / writeback) integer pipeline with
// an internal register file, eight-op ALU, EX-stage forwarding from the EX/WB
// register, global stall (en), sticky HALT and a retire counter.
module pipe3_alu_core #(
  parameter int DATA_W     = 32,
  parameter int NREGS      = 32,
  parameter int IMEM_DEPTH = 32,
  parameter bit R0_ZERO    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              halted,
  output logic [31:0]       retired
);

  localparam int AW = $clog2(NREGS);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd7;

  // The instruction memory is external; its depth only constrains legal configurations.
  if (NREGS < 2 || NREGS > 32 || (NREGS & (NREGS - 1)) != 0 || IMEM_DEPTH < 1) begin : g_param_check
    $error("pipe3_alu_core: NREGS must be a power of 2 in 2..32 and IMEM_DEPTH >= 1");
  end

  function automatic logic signed [DATA_W-1:0] alu(
    input logic [2:0]               op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic [13:0]              imm
  );
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_LDI:  alu = $signed(DATA_W'(imm));
      default: alu = '0;
    endcase
  endfunction

  logic [31:0]              pc_p0;
  logic [31:0]              instr_p1;
  logic                     vld_p1;
  logic [DATA_W-1:0]        regs [NREGS];

  logic [2:0]               op_p1;
  logic [4:0]               rd_p1;
  logic [AW-1:0]            rs1_p1;
  logic [AW-1:0]            rs2_p1;
  logic [13:0]              imm_p1;
  logic                     ex_halt;
  logic                     ex_wr;
  logic [AW-1:0]            wb_idx;
  logic                     wb_commit;
  logic                     fwd_ok;
  logic signed [DATA_W-1:0] opa_p1;
  logic signed [DATA_W-1:0] opb_p1;
  logic signed [DATA_W-1:0] res_p1;

  assign imem_addr = pc_p0;

  assign op_p1   = instr_p1[31:29];
  assign rd_p1   = instr_p1[28:24];
  assign rs1_p1  = instr_p1[19 +: AW];
  assign rs2_p1  = instr_p1[14 +: AW];
  assign imm_p1  = instr_p1[13:0];
  assign ex_halt = vld_p1 && (op_p1 == OP_HALT);
  assign ex_wr   = vld_p1 && (op_p1 <= OP_LDI);

  // A write to the hard-wired zero register still flows down the pipe but commits nothing.
  assign wb_idx    = wb_addr[AW-1:0];
  assign wb_commit = wb_valid && !(R0_ZERO && wb_idx == '0);
  assign fwd_ok    = wb_commit;

  assign dbg_rdata = (R0_ZERO && dbg_raddr[AW-1:0] == '0) ? '0 : regs[dbg_raddr[AW-1:0]];

  // ---- execute stage (p1): operand read with bypass from EX/WB, then ALU ----
  // Operand select: the one-ahead producer sits in EX/WB, the two-ahead one is already in regs.
  always_comb begin
    opa_p1 = (R0_ZERO && rs1_p1 == '0) ? '0 : $signed(regs[rs1_p1]);
    opb_p1 = (R0_ZERO && rs2_p1 == '0) ? '0 : $signed(regs[rs2_p1]);
    if (fwd_ok && rs1_p1 == wb_idx) opa_p1 = $signed(wb_data);
    if (fwd_ok && rs2_p1 == wb_idx) opb_p1 = $signed(wb_data);
    res_p1 = alu(op_p1, opa_p1, opb_p1, imm_p1);
  end

  // ---- fetch stage (p0) -> IF/EX, EX -> EX/WB control ----
  // Control state: pc, stage valids, HALT latch and retire counter; en=0 freezes all of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0    <= '0;
      vld_p1   <= 1'b0;
      wb_valid <= 1'b0;
      halted   <= 1'b0;
      retired  <= '0;
    end else if (en) begin
      if (!halted) begin
        pc_p0  <= pc_p0 + 32'd4;
        vld_p1 <= !ex_halt;
      end else begin
        vld_p1 <= 1'b0;
      end
      wb_valid <= ex_wr;
      if (ex_halt) halted <= 1'b1;
      if (wb_commit) retired <= retired + 32'd1;
    end
  end

  // IF/EX instruction latch; qualified by vld_p1 so it needs no reset.
  always_ff @(posedge clk) begin
    if (en && !halted) instr_p1 <= imem_rdata;
  end

  // ---- EX/WB register (p2) ----
  // Result latch: holds the last register write until the next one leaves EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_addr <= '0;
      wb_data <= '0;
    end else if (en && ex_wr) begin
      wb_addr <= rd_p1;
      wb_data <= res_p1;
    end
  end

  // ---- writeback into the register file ----
  // Register file: cleared by reset, written from EX/WB only while the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (en && wb_commit) begin
      regs[wb_idx] <= wb_data;
    end
  end

endmodule

// File: tb/tb_pipe3_alu_core.sv
// Bench for pipe3_alu_core: directed program table, hand-written stall / reset /
// latency / wrap sequences, and random programs checked against an ISA-level model.
module tb_pipe3_alu_core;

  localparam logic [31:0] HALT_W = 32'hE000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en;
  logic [31:0] imem_addr, imem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        halted;
  logic [31:0] retired;
  logic [31:0] imem [32];

  logic        rst2, en2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic        wb_valid2;
  logic [4:0]  wb_addr2;
  logic [31:0] wb_data2;
  logic [4:0]  dbg_raddr2;
  logic [31:0] dbg_rdata2;
  logic        halted2;
  logic [31:0] retired2;
  logic [31:0] imem2 [4];

  assign imem_rdata  = imem[imem_addr[6:2]];
  assign imem_rdata2 = imem2[imem_addr2[3:2]];

  pipe3_alu_core u_dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .halted(halted), .retired(retired)
  );

  pipe3_alu_core #(.DATA_W(32), .NREGS(8), .IMEM_DEPTH(4), .R0_ZERO(1'b0)) u_dut4 (
    .clk(clk), .rst(rst2), .en(en2),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .wb_valid(wb_valid2), .wb_addr(wb_addr2), .wb_data(wb_data2),
    .dbg_raddr(dbg_raddr2), .dbg_rdata(dbg_rdata2),
    .halted(halted2), .retired(retired2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0][31:0] prog;
    logic [4:0]       ra;
    logic [31:0]      va;
    logic [4:0]       rb;
    logic [31:0]      vb;
    logic [31:0]      ret;
    logic [31:0]      pc;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  logic [31:0] m_regs [32];
  int          m_ret;
  logic [31:0] m_pc;

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [13:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reg(input string nm, input logic [4:0] idx, input logic [31:0] exp);
    dbg_raddr = idx;
    #1;
    chk(nm, dbg_rdata, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic load_vec(input int v);
    for (int i = 0; i < 32; i++) imem[i] = (i < 8) ? vecs[v].prog[i] : HALT_W;
  endtask

  task automatic run_to_halt(input int max_cyc, input bit rnd_en);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      en = rnd_en ? ($urandom_range(0, 9) < 7) : 1'b1;
      step();
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
    en = 1'b1;
    step();
    step();
    chk("halt_reached", {31'b0, ok}, 32'd1);
  endtask

  // Instruction-set interpreter: runs the program in imem sequentially to its HALT.
  task automatic model_run();
    logic [31:0] pc, w, a, b, r;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_ret = 0;
    pc    = '0;
    for (int g = 0; g < 1000; g++) begin
      w = imem[pc[6:2]];
      if (w[31:29] == 3'd7) break;
      a = m_regs[w[23:19]];
      b = m_regs[w[18:14]];
      case (w[31:29])
        3'd0:    r = a + b;
        3'd1:    r = a - b;
        3'd2:    r = a & b;
        3'd3:    r = a | b;
        3'd4:    r = a ^ b;
        3'd5:    r = {18'b0, w[13:0]};
        default: r = '0;
      endcase
      if (w[31:29] <= 3'd5 && w[28:24] != 5'd0) begin
        m_regs[w[28:24]] = r;
        m_ret++;
      end
      pc = pc + 32'd4;
    end
    m_pc = pc + 32'd8;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; dbg_raddr = '0;
    rst2 = 1'b1; en2 = 1'b1; dbg_raddr2 = '0;
    for (int i = 0; i < 32; i++) imem[i] = HALT_W;
    imem2[0] = mk(3'd5, 5'd8, 5'd0, 5'd0, 14'd1);
    imem2[1] = mk(3'd0, 5'd0, 5'd0, 5'd0, 14'd0);
    imem2[2] = mk(3'd0, 5'd0, 5'd0, 5'd0, 14'd0);
    imem2[3] = mk(3'd6, 5'd0, 5'd0, 5'd0, 14'd0);

    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < 8; i++) vecs[v].prog[i] = HALT_W;
    end
    vecs[0].prog[0] = mk(3'd5, 5'd1, 5'd0, 5'd0, 14'd5);
    vecs[0].prog[1] = mk(3'd5, 5'd2, 5'd0, 5'd0, 14'd3);
    vecs[0].prog[2] = mk(3'd0, 5'd3, 5'd1, 5'd2, 14'd0);
    vecs[0].prog[3] = mk(3'd1, 5'd4, 5'd2, 5'd1, 14'd0);
    vecs[0].ra = 5'd3; vecs[0].va = 32'd8; vecs[0].rb = 5'd4; vecs[0].vb = 32'hFFFF_FFFE;
    vecs[0].ret = 32'd4; vecs[0].pc = 32'd24;
    vecs[1].prog[0] = mk(3'd5, 5'd1, 5'd0, 5'd0, 14'd7);
    vecs[1].prog[1] = mk(3'd0, 5'd1, 5'd1, 5'd1, 14'd0);
    vecs[1].prog[2] = mk(3'd0, 5'd1, 5'd1, 5'd1, 14'd0);
    vecs[1].ra = 5'd1; vecs[1].va = 32'd28; vecs[1].rb = 5'd0; vecs[1].vb = 32'd0;
    vecs[1].ret = 32'd3; vecs[1].pc = 32'd20;
    vecs[2].prog[0] = mk(3'd5, 5'd0, 5'd0, 5'd0, 14'd1);
    vecs[2].ra = 5'd0; vecs[2].va = 32'd0; vecs[2].rb = 5'd1; vecs[2].vb = 32'd0;
    vecs[2].ret = 32'd0; vecs[2].pc = 32'd12;
    vecs[3].prog[1] = mk(3'd5, 5'd5, 5'd0, 5'd0, 14'd9);
    vecs[3].ra = 5'd5; vecs[3].va = 32'd0; vecs[3].rb = 5'd0; vecs[3].vb = 32'd0;
    vecs[3].ret = 32'd0; vecs[3].pc = 32'd8;
    vecs[4].prog[0] = mk(3'd5, 5'd6, 5'd0, 5'd0, 14'h3FFF);
    vecs[4].prog[1] = mk(3'd5, 5'd7, 5'd0, 5'd0, 14'h0F0F);
    vecs[4].prog[2] = mk(3'd2, 5'd8, 5'd6, 5'd7, 14'd0);
    vecs[4].prog[3] = mk(3'd4, 5'd10, 5'd6, 5'd7, 14'd0);
    vecs[4].ra = 5'd8; vecs[4].va = 32'h0F0F; vecs[4].rb = 5'd10; vecs[4].vb = 32'h30F0;
    vecs[4].ret = 32'd4; vecs[4].pc = 32'd24;
    vecs[5].prog[0] = mk(3'd6, 5'd0, 5'd0, 5'd0, 14'd0);
    vecs[5].prog[1] = mk(3'd5, 5'd2, 5'd0, 5'd0, 14'd1);
    vecs[5].prog[2] = mk(3'd1, 5'd3, 5'd0, 5'd2, 14'd0);
    vecs[5].ra = 5'd3; vecs[5].va = 32'hFFFF_FFFF; vecs[5].rb = 5'd2; vecs[5].vb = 32'd1;
    vecs[5].ret = 32'd2; vecs[5].pc = 32'd20;
    vecs[6].prog[0] = mk(3'd5, 5'd1, 5'd0, 5'd0, 14'h00F0);
    vecs[6].prog[1] = mk(3'd5, 5'd2, 5'd0, 5'd0, 14'h0F00);
    vecs[6].prog[2] = mk(3'd3, 5'd3, 5'd1, 5'd2, 14'd0);
    vecs[6].prog[3] = mk(3'd2, 5'd4, 5'd3, 5'd1, 14'd0);
    vecs[6].ra = 5'd3; vecs[6].va = 32'h0FF0; vecs[6].rb = 5'd4; vecs[6].vb = 32'h00F0;
    vecs[6].ret = 32'd4; vecs[6].pc = 32'd24;

    // Directed program table
    for (int v = 0; v < NV; v++) begin
      load_vec(v);
      do_reset();
      run_to_halt(200, 1'b0);
      chk_reg($sformatf("v%0d_reg_a", v), vecs[v].ra, vecs[v].va);
      chk_reg($sformatf("v%0d_reg_b", v), vecs[v].rb, vecs[v].vb);
      chk($sformatf("v%0d_retired", v), retired, vecs[v].ret);
      chk($sformatf("v%0d_pc", v), imem_addr, vecs[v].pc);
    end

    // Reset state, sampled with rst still asserted over a dirty pipeline
    rst = 1'b1;
    step();
    chk("rst_pc", imem_addr, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_addr", {27'b0, wb_addr}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk_reg("rst_r3", 5'd3, 32'd0);
    chk_reg("rst_r4", 5'd4, 32'd0);
    rst = 1'b0;

    // Latency: LDI r1,5 fetched at edge 1, in EX/WB after edge 2, visible after edge 3
    load_vec(0);
    do_reset();
    step();
    chk("lat_wbv_e1", {31'b0, wb_valid}, 32'd0);
    step();
    chk("lat_wbv_e2", {31'b0, wb_valid}, 32'd1);
    chk("lat_wba_e2", {27'b0, wb_addr}, 32'd1);
    chk("lat_wbd_e2", wb_data, 32'd5);
    chk_reg("lat_r1_e2", 5'd1, 32'd0);
    step();
    chk_reg("lat_r1_e3", 5'd1, 32'd5);
    chk("lat_ret_e3", retired, 32'd1);
    run_to_halt(200, 1'b0);

    // Stall for three cycles with a dependent chain in flight
    load_vec(1);
    do_reset();
    step();
    step();
    en = 1'b0;
    step(); step(); step();
    chk("stall_pc", imem_addr, 32'd8);
    chk("stall_retired", retired, 32'd0);
    chk("stall_wbv", {31'b0, wb_valid}, 32'd1);
    chk("stall_wbd", wb_data, 32'd7);
    chk_reg("stall_r1", 5'd1, 32'd0);
    en = 1'b1;
    run_to_halt(200, 1'b0);
    chk_reg("stall_r1_final", 5'd1, 32'd28);
    chk("stall_ret_final", retired, 32'd3);
    chk("stall_pc_final", imem_addr, 32'd20);

    // Reset while ADD r3 is in EX
    load_vec(0);
    do_reset();
    step(); step(); step();
    rst = 1'b1;
    step();
    chk_reg("midrst_r1", 5'd1, 32'd0);
    chk_reg("midrst_r2", 5'd2, 32'd0);
    chk_reg("midrst_r3", 5'd3, 32'd0);
    chk("midrst_retired", retired, 32'd0);
    chk("midrst_wbv", {31'b0, wb_valid}, 32'd0);
    chk("midrst_pc", imem_addr, 32'd0);
    rst = 1'b0;

    // Four-word memory wraps; NREGS=8 maps r8 onto r0, which is ordinary here
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    step(); step(); step(); step(); step();
    chk("wrap_pc_e5", imem_addr2, 32'd20);
    chk("wrap_r0_e5", dbg_rdata2, 32'd4);
    chk("wrap_ret_e5", retired2, 32'd3);
    step();
    chk("wrap_r0_e6", dbg_rdata2, 32'd4);
    step();
    chk("wrap_r0_e7", dbg_rdata2, 32'd1);
    chk("wrap_ret_e7", retired2, 32'd4);
    rst2 = 1'b1;

    // Random programs with random stalls against the interpreter
    for (int p = 0; p < 8; p++) begin
      int len;
      len = $urandom_range(3, 28);
      for (int i = 0; i < 32; i++) begin
        if (i < len)
          imem[i] = mk(3'($urandom_range(0, 6)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 14'($urandom));
        else if (i == len)
          imem[i] = HALT_W;
        else
          imem[i] = mk(3'd5, 5'($urandom_range(1, 7)), 5'd0, 5'd0, 14'($urandom));
      end
      model_run();
      do_reset();
      run_to_halt(2000, 1'b1);
      for (int r = 0; r < 32; r++) chk_reg($sformatf("rnd%0d_r%0d", p, r), 5'(r), m_regs[r]);
      chk($sformatf("rnd%0d_retired", p), retired, 32'(m_ret));
      chk($sformatf("rnd%0d_pc", p), imem_addr, m_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
